// File: rtl/axi_split_pkg.sv
// Shared definitions for the AW boundary splitter.
//   - AXI burst/size encodings driven on the AW channel
//   - 4 KB boundary size and its equivalent in 32-bit beats
//   - FSM state encoding
//   - beats_to_boundary(): beats left before the next 4 KB boundary
package axi_split_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  localparam int unsigned BOUNDARY_BYTES = 4096;
  localparam int unsigned BOUNDARY_BEATS = BOUNDARY_BYTES / 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_PUSH = 2'd2,
    ST_AW   = 2'd3
  } split_state_t;

  // Word offset within the 4 KB page -> beats until the page ends (1..1024).
  function automatic logic [10:0] beats_to_boundary(input logic [9:0] word_ofs);
    return 11'(BOUNDARY_BEATS) - {1'b0, word_ofs};
  endfunction

endpackage

// File: rtl/burst_len_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST_LEN, to_bound).
// Ports:
//   remaining  in  17  beats still to issue for the command (1..65536)
//   to_bound   in  11  beats until the next 4 KB boundary (1..1024)
//   beats      out  9  beats for the next burst (1..MAX_BURST_LEN)
module burst_len_calc #(
  parameter int MAX_BURST_LEN = 256
) (
  input  logic [16:0] remaining,
  input  logic [10:0] to_bound,
  output logic [8:0]  beats
);

  localparam logic [10:0] MAX_B11 = 11'(MAX_BURST_LEN);
  localparam logic [8:0]  MAX_B9  = 9'(MAX_BURST_LEN);

  logic [8:0] cap;

  // cap never exceeds MAX_BURST_LEN (<= 256), so 9 bits hold both candidates.
  always_comb begin
    cap = MAX_B9;
    if (to_bound < MAX_B11) cap = to_bound[8:0];
    beats = cap;
    if (remaining < {8'd0, cap}) beats = remaining[8:0];
  end

endmodule

// File: rtl/axi_aw_boundary_split.sv
// Write-command splitter: breaks (start address, beat count) commands into
// AXI INCR bursts that never cross a 4 KB boundary and never exceed
// MAX_BURST_LEN beats. Each burst length is pushed into the burst-length FIFO
// before the matching AW transaction is issued.
//
// Optional feature macro: AW_SPLIT_ALIGN_CHK_EN
//   defined   : commands with addr[1:0] != 0 are dropped and cmd_err pulses
//   undefined : addr[1:0] is forced to 0, cmd_err tied low
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_cmd_addr/len/valid/ready command input (len = beats - 1)
//   m_axi_aw*                  AXI AW channel (INCR, 4-byte beats)
//   burst_len_fifo_wen/din     burst length (beats - 1) to W-channel stage
//   burst_len_fifo_full_n      FIFO has room
//   cmd_done                   last AW of a command accepted (same cycle)
//   cmd_err                    misaligned command dropped (cycle after accept)
module axi_aw_boundary_split
  import axi_split_pkg::*;
#(
  parameter int MAX_BURST_LEN = 256,
  // Kept for instantiation compatibility; registers here update with no delay.
  parameter int SIM_DELAY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_cmd_addr,
  input  logic [15:0] s_cmd_len,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic        burst_len_fifo_wen,
  output logic [7:0]  burst_len_fifo_din,
  input  logic        burst_len_fifo_full_n,
  output logic        cmd_done,
  output logic        cmd_err
);

  if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256 ||
      (MAX_BURST_LEN & (MAX_BURST_LEN - 1)) != 0) begin : g_bad_max_len
    $error("MAX_BURST_LEN must be a power of two in 1..256");
  end
  if (SIM_DELAY < 0) begin : g_bad_sim_delay
    $error("SIM_DELAY must be non-negative");
  end

  split_state_t state;
  logic         ready_q;
  logic [31:0]  addr_q;
  logic [16:0]  remaining_q;
  logic [7:0]   awlen_q;

  logic [10:0]  to_bound;
  logic [8:0]   calc_beats;
  logic [8:0]   burst_beats;
  logic         cmd_fire;
  logic         aw_fire;
  logic         last_burst;
  logic         cmd_drop;

  assign to_bound    = beats_to_boundary(addr_q[11:2]);
  assign burst_beats = {1'b0, awlen_q} + 9'd1;
  assign last_burst  = (remaining_q == {8'd0, burst_beats});
  assign cmd_fire    = s_cmd_valid && ready_q;
  assign aw_fire     = (state == ST_AW) && m_axi_awready;

  burst_len_calc #(
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_burst_len_calc (
    .remaining(remaining_q),
    .to_bound (to_bound),
    .beats    (calc_beats)
  );

`ifdef AW_SPLIT_ALIGN_CHK_EN
  logic err_q;

  assign cmd_drop = (s_cmd_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= cmd_fire && cmd_drop;
  end

  assign cmd_err = err_q;
`else
  assign cmd_drop = 1'b0;
  assign cmd_err  = 1'b0;
`endif

  // ready_q mirrors "state is IDLE" but stays low for the first cycle after
  // reset release, so the command port is closed while rst_n is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      awlen_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (cmd_fire && !cmd_drop) begin
            // Masking keeps every address bit referenced in both builds.
            addr_q      <= s_cmd_addr & 32'hFFFF_FFFC;
            remaining_q <= {1'b0, s_cmd_len} + 17'd1;
            ready_q     <= 1'b0;
            state       <= ST_CALC;
          end
        end
        ST_CALC: begin
          awlen_q <= 8'(calc_beats - 9'd1);
          state   <= ST_PUSH;
        end
        ST_PUSH: begin
          if (burst_len_fifo_full_n) state <= ST_AW;
        end
        ST_AW: begin
          if (m_axi_awready) begin
            addr_q      <= addr_q + {21'd0, burst_beats, 2'b00};
            remaining_q <= remaining_q - {8'd0, burst_beats};
            if (last_burst) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_cmd_ready        = ready_q;
  assign m_axi_awaddr       = addr_q;
  assign m_axi_awlen        = awlen_q;
  assign m_axi_awsize       = AXI_SIZE_4B;
  assign m_axi_awburst      = AXI_BURST_INCR;
  assign m_axi_awvalid      = (state == ST_AW);
  assign burst_len_fifo_wen = (state == ST_PUSH) && burst_len_fifo_full_n;
  assign burst_len_fifo_din = awlen_q;
  assign cmd_done           = aw_fire && last_burst;

endmodule

// File: tb/tb_axi_aw_boundary_split.sv
module tb_axi_aw_boundary_split;

  localparam int MAXB = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_cmd_addr;
  logic [15:0] s_cmd_len;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic        burst_len_fifo_wen;
  logic [7:0]  burst_len_fifo_din;
  logic        burst_len_fifo_full_n;
  logic        cmd_done;
  logic        cmd_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];

  always #5 clk = ~clk;

  axi_aw_boundary_split #(.MAX_BURST_LEN(MAXB), .SIM_DELAY(1)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_cmd_addr           (s_cmd_addr),
    .s_cmd_len            (s_cmd_len),
    .s_cmd_valid          (s_cmd_valid),
    .s_cmd_ready          (s_cmd_ready),
    .m_axi_awaddr         (m_axi_awaddr),
    .m_axi_awlen          (m_axi_awlen),
    .m_axi_awsize         (m_axi_awsize),
    .m_axi_awburst        (m_axi_awburst),
    .m_axi_awvalid        (m_axi_awvalid),
    .m_axi_awready        (m_axi_awready),
    .burst_len_fifo_wen   (burst_len_fifo_wen),
    .burst_len_fifo_din   (burst_len_fifo_din),
    .burst_len_fifo_full_n(burst_len_fifo_full_n),
    .cmd_done             (cmd_done),
    .cmd_err              (cmd_err)
  );

  // Reference: walk the command in beats, cutting at page ends and MAXB.
  task automatic model_cmd(input logic [31:0] a_in, input logic [15:0] l);
    longint unsigned a;
    int left;
    a = 64'(a_in & 32'hFFFF_FFFC);
    left = int'(l) + 1;
    exp_addr.delete();
    exp_len.delete();
    while (left > 0) begin
      int room;
      int b;
      room = (4096 - int'(a % 4096)) / 4;
      b = left;
      if (MAXB < b) b = MAXB;
      if (room < b) b = room;
      exp_addr.push_back(32'(a));
      exp_len.push_back(8'(b - 1));
      a = (a + 64'(4 * b)) % 64'h1_0000_0000;
      left -= b;
    end
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [15:0] l,
                         input int stall_pct, input string name);
    int n, fi, ai, cyc;
    logic hold, exp_done;
    logic [31:0] h_addr;
    logic [7:0]  h_len;
    model_cmd(a, l);
    n = exp_addr.size();
    fi = 0; ai = 0; hold = 1'b0; h_addr = '0; h_len = '0;
    cyc = 0;
    @(negedge clk);
    while (s_cmd_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (s_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s cmd_ready_wait: got %b want 1", name, s_cmd_ready);
      return;
    end
    s_cmd_addr = a; s_cmd_len = l; s_cmd_valid = 1'b1;
    @(negedge clk);
    s_cmd_valid = 1'b0; s_cmd_addr = $urandom; s_cmd_len = 16'($urandom);
    checks++;
    if (s_cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_busy: got %b want 0", name, s_cmd_ready);
    end
    cyc = 0;
    while (ai < n && cyc < 300 * n + 50) begin
      burst_len_fifo_full_n = ($urandom_range(99) >= stall_pct);
      m_axi_awready         = ($urandom_range(99) >= stall_pct);
      #1;
      if (burst_len_fifo_wen) begin
        checks++;
        if (!burst_len_fifo_full_n) begin
          failures++;
          $display("FAIL %s wen_while_full: got wen=1 want 0", name);
        end else if (fi >= n) begin
          failures++;
          $display("FAIL %s extra_fifo_write: got write %0d want %0d writes", name, fi + 1, n);
        end else if (burst_len_fifo_din !== exp_len[fi]) begin
          failures++;
          $display("FAIL %s fifo_din[%0d]: got %0d want %0d", name, fi, burst_len_fifo_din, exp_len[fi]);
        end
        fi++;
      end
      if (hold) begin
        checks++;
        if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== h_addr || m_axi_awlen !== h_len) begin
          failures++;
          $display("FAIL %s aw_stable: got v=%b a=%h l=%0d want v=1 a=%h l=%0d",
                   name, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, h_addr, h_len);
        end
      end
      exp_done = m_axi_awvalid && m_axi_awready && (ai == n - 1);
      checks++;
      if (cmd_done !== exp_done) begin
        failures++;
        $display("FAIL %s cmd_done: got %b want %b", name, cmd_done, exp_done);
      end
      checks++;
      if (cmd_err !== 1'b0) begin
        failures++;
        $display("FAIL %s cmd_err: got %b want 0", name, cmd_err);
      end
      if (m_axi_awvalid === 1'b1) begin
        if (m_axi_awready) begin
          checks++;
          if (ai >= fi) begin
            failures++;
            $display("FAIL %s aw_before_fifo[%0d]: got aw %0d want fifo writes > %0d", name, ai, ai, fi);
          end else if (m_axi_awaddr !== exp_addr[ai] || m_axi_awlen !== exp_len[ai] ||
                       m_axi_awsize !== 3'b010 || m_axi_awburst !== 2'b01) begin
            failures++;
            $display("FAIL %s aw[%0d]: got a=%h l=%0d s=%b b=%b want a=%h l=%0d s=010 b=01",
                     name, ai, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                     exp_addr[ai], exp_len[ai]);
          end
          ai++;
          hold = 1'b0;
        end else begin
          hold = 1'b1; h_addr = m_axi_awaddr; h_len = m_axi_awlen;
        end
      end else begin
        hold = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ai != n || fi != n) begin
      failures++;
      $display("FAIL %s burst_count: got aw=%0d fifo=%0d want %0d", name, ai, fi, n);
    end
    m_axi_awready = 1'b0;
    burst_len_fifo_full_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_addr = '0; s_cmd_len = '0;
    m_axi_awready = 1'b0; burst_len_fifo_full_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_cmd_ready, m_axi_awvalid, burst_len_fifo_wen, cmd_done, cmd_err} !== 5'b0 ||
        m_axi_awaddr !== 32'h0 || m_axi_awlen !== 8'h0 || burst_len_fifo_din !== 8'h0) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b v=%b wen=%b done=%b err=%b a=%h l=%0d din=%0d want all 0",
               s_cmd_ready, m_axi_awvalid, burst_len_fifo_wen, cmd_done, cmd_err,
               m_axi_awaddr, m_axi_awlen, burst_len_fifo_din);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 0", s_cmd_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (s_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b want 1", s_cmd_ready);
    end
  endtask

  // Accept at cycle 0 -> wen cycle 2 -> awvalid cycle 3; AW held under backpressure.
  task automatic test_latency();
    @(negedge clk);
    burst_len_fifo_full_n = 1'b1; m_axi_awready = 1'b0;
    s_cmd_addr = 32'h0; s_cmd_len = 16'd15; s_cmd_valid = 1'b1;
    @(negedge clk); s_cmd_valid = 1'b0; #1;
    checks++;
    if (burst_len_fifo_wen !== 1'b0 || m_axi_awvalid !== 1'b0) begin
      failures++;
      $display("FAIL latency_c1: got wen=%b v=%b want 0 0", burst_len_fifo_wen, m_axi_awvalid);
    end
    @(negedge clk); #1;
    checks++;
    if (burst_len_fifo_wen !== 1'b1 || burst_len_fifo_din !== 8'd15 || m_axi_awvalid !== 1'b0) begin
      failures++;
      $display("FAIL latency_c2: got wen=%b din=%0d v=%b want 1 15 0",
               burst_len_fifo_wen, burst_len_fifo_din, m_axi_awvalid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h0 || m_axi_awlen !== 8'd15 ||
          burst_len_fifo_wen !== 1'b0 || cmd_done !== 1'b0) begin
        failures++;
        $display("FAIL aw_hold[%0d]: got v=%b a=%h l=%0d wen=%b done=%b want 1 0 15 0 0",
                 i, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, burst_len_fifo_wen, cmd_done);
      end
    end
    @(negedge clk); m_axi_awready = 1'b1; #1;
    checks++;
    if (cmd_done !== 1'b1 || m_axi_awvalid !== 1'b1) begin
      failures++;
      $display("FAIL single_done: got done=%b v=%b want 1 1", cmd_done, m_axi_awvalid);
    end
    @(negedge clk); m_axi_awready = 1'b0; #1;
    checks++;
    if (cmd_done !== 1'b0 || m_axi_awvalid !== 1'b0 || s_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_after: got done=%b v=%b rdy=%b want 0 0 1", cmd_done, m_axi_awvalid, s_cmd_ready);
    end
  endtask

  task automatic test_full_stall();
    @(negedge clk);
    burst_len_fifo_full_n = 1'b0; m_axi_awready = 1'b0;
    s_cmd_addr = 32'h0000_2000; s_cmd_len = 16'd15; s_cmd_valid = 1'b1;
    @(negedge clk); s_cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (burst_len_fifo_wen !== 1'b0 || m_axi_awvalid !== 1'b0) begin
        failures++;
        $display("FAIL full_stall[%0d]: got wen=%b v=%b want 0 0", i, burst_len_fifo_wen, m_axi_awvalid);
      end
    end
    @(negedge clk); burst_len_fifo_full_n = 1'b1; #1;
    checks++;
    if (burst_len_fifo_wen !== 1'b1 || burst_len_fifo_din !== 8'd15) begin
      failures++;
      $display("FAIL full_resume: got wen=%b din=%0d want 1 15", burst_len_fifo_wen, burst_len_fifo_din);
    end
    @(negedge clk); m_axi_awready = 1'b1; #1;
    checks++;
    if (burst_len_fifo_wen !== 1'b0 || m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h0000_2000 ||
        m_axi_awlen !== 8'd15 || cmd_done !== 1'b1) begin
      failures++;
      $display("FAIL full_aw: got wen=%b v=%b a=%h l=%0d done=%b want 0 1 00002000 15 1",
               burst_len_fifo_wen, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, cmd_done);
    end
    @(negedge clk); m_axi_awready = 1'b0;
  endtask

`ifdef AW_SPLIT_ALIGN_CHK_EN
  task automatic test_align_err();
    @(negedge clk);
    s_cmd_addr = 32'h0000_0002; s_cmd_len = 16'd3; s_cmd_valid = 1'b1;
    burst_len_fifo_full_n = 1'b1; m_axi_awready = 1'b1;
    @(negedge clk); s_cmd_valid = 1'b0; #1;
    checks++;
    if (cmd_err !== 1'b1 || s_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL align_err_pulse: got err=%b rdy=%b want 1 1", cmd_err, s_cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (cmd_err !== 1'b0 || burst_len_fifo_wen !== 1'b0 || m_axi_awvalid !== 1'b0) begin
        failures++;
        $display("FAIL align_err_quiet[%0d]: got err=%b wen=%b v=%b want 0 0 0",
                 i, cmd_err, burst_len_fifo_wen, m_axi_awvalid);
      end
    end
    m_axi_awready = 1'b0;
  endtask
`else
  task automatic test_unaligned();
    run_cmd(32'h0000_1FFE, 16'd3, 0, "unaligned_forced");
  endtask
`endif

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    @(negedge clk);
    burst_len_fifo_full_n = 1'b1; m_axi_awready = 1'b0;
    s_cmd_addr = 32'h0; s_cmd_len = 16'd599; s_cmd_valid = 1'b1;
    @(negedge clk); s_cmd_valid = 1'b0;
    while (m_axi_awvalid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (m_axi_awvalid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reach_aw: got v=%b want 1", m_axi_awvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_cmd_ready, m_axi_awvalid, burst_len_fifo_wen, cmd_done, cmd_err} !== 5'b0 ||
        m_axi_awaddr !== 32'h0 || m_axi_awlen !== 8'h0 || burst_len_fifo_din !== 8'h0) begin
      failures++;
      $display("FAIL midreset_values: got rdy=%b v=%b wen=%b a=%h l=%0d din=%0d want all 0",
               s_cmd_ready, m_axi_awvalid, burst_len_fifo_wen, m_axi_awaddr, m_axi_awlen,
               burst_len_fifo_din);
    end
    @(negedge clk); rst_n = 1'b1; m_axi_awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (burst_len_fifo_wen !== 1'b0 || m_axi_awvalid !== 1'b0 || s_cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_idle[%0d]: got wen=%b v=%b rdy=%b want 0 0 1",
                 i, burst_len_fifo_wen, m_axi_awvalid, s_cmd_ready);
      end
    end
    m_axi_awready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [15:0] l;
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      if ($urandom_range(1) == 1)
        a = (a & 32'hFFFF_F000) | 32'(4096 - 4 * $urandom_range(1, 40)) | (a & 32'h3);
`ifdef AW_SPLIT_ALIGN_CHK_EN
      a = a & 32'hFFFF_FFFC;
`endif
      l = 16'($urandom_range(0, 1100));
      run_cmd(a, l, $urandom_range(0, 60), "random");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_full_stall();
    run_cmd(32'h0000_0FF0, 16'd7, 0, "boundary_split");
    run_cmd(32'h0000_0000, 16'd599, 0, "max_burst");
    run_cmd(32'h0000_0000, 16'd599, 40, "max_burst_stall");
    run_cmd(32'hFFFF_FFF0, 16'd15, 30, "addr_wrap");
`ifdef AW_SPLIT_ALIGN_CHK_EN
    test_align_err();
`else
    test_unaligned();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
